snake_matrix_scan: RTL and testbench

//  Display stage directly downstream of the snake game core. Accepts the 8x8 game-field snapshot

---
 rtl/snake_pkg.sv | 17 +
 rtl/snake_matrix_scan_if.sv | 11 +
 rtl/snake_field_dbuf.sv | 55 +++++
 rtl/snake_matrix_scan.sv | 135 +++++++++++++
 tb/tb_snake_matrix_scan.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared snake field geometry, scan FSM states and pixel indexing
package snake_pkg;

  localparam int FIELD_ROWS = 8;
  localparam int FIELD_COLS = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_ON
  } state_e;

  function automatic int idx(input int r, input int c);
    return r * FIELD_COLS + c;
  endfunction

endpackage

// File: rtl/snake_matrix_scan_if.sv
// rtl/snake_matrix_scan_if.sv - field snapshot valid/ready channel from the game core
interface snake_matrix_scan_if #(
  parameter int W = snake_pkg::FIELD_ROWS * snake_pkg::FIELD_COLS
);
  logic         upd_valid;
  logic         upd_ready;
  logic [W-1:0] upd_field;

  modport master (output upd_valid, output upd_field, input upd_ready);
  modport slave  (input upd_valid, input upd_field, output upd_ready);
endinterface

// File: rtl/snake_field_dbuf.sv
// rtl/snake_field_dbuf.sv - pending/active field double buffer with snapshot handshake
module snake_field_dbuf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         upd_valid,
  output logic         upd_ready,
  input  logic [W-1:0] upd_field,
  input  logic         swap_req,
  input  logic         swap_frees,
  output logic         pend_full,
  output logic [W-1:0] active
);

  logic [W-1:0] pend_q, pend_d;
  logic [W-1:0] active_q, active_d;
  logic         pend_full_q, pend_full_d;
  logic         swap;
  logic         accept;

  // A frame-boundary swap empties the slot on the same edge, so a waiting producer may refill it.
  always_comb begin
    swap        = swap_req && pend_full_q;
    upd_ready   = !pend_full_q || (swap && swap_frees);
    accept      = upd_valid && upd_ready;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;
    if (swap) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = upd_field;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      active_q    <= '0;
      pend_full_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      active_q    <= active_d;
      pend_full_q <= pend_full_d;
    end
  end

  assign pend_full = pend_full_q;
  assign active    = active_q;

endmodule

// File: rtl/snake_matrix_scan.sv
// rtl/snake_matrix_scan.sv - row-multiplexed LED matrix scanner for the snake field
// SNAKE_SCAN_BRIGHTNESS_EN adds a 3-bit bright input that shortens the lit part of each row.
module snake_matrix_scan
  import snake_pkg::*;
#(
  parameter int ROWS    = FIELD_ROWS,
  parameter int COLS    = FIELD_COLS,
  parameter int DWELL   = 1000,
  parameter int BLANK   = 4,
  parameter int OCC_LOW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  snake_matrix_scan_if.slave upd,
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
  input  logic [2:0]      bright,
`endif
  output logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_on,
  output logic            frame_start
);

  localparam int CW = $clog2((DWELL > BLANK) ? DWELL : BLANK);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  state_e                 state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   swap_req;
  logic                   swap_frees;
  logic                   pend_full;
  logic [ROWS*COLS-1:0]   active;
  logic [COLS-1:0]        row_bits;
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
  logic [2:0]             bright_q, bright_d;
`endif

  snake_field_dbuf #(.W(ROWS * COLS)) u_dbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid  (upd.upd_valid),
    .upd_ready  (upd.upd_ready),
    .upd_field  (upd.upd_field),
    .swap_req   (swap_req),
    .swap_frees (swap_frees),
    .pend_full  (pend_full),
    .active     (active)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      cnt_q    <= '0;
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
      bright_q <= 3'd7;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
      bright_q <= bright_d;
`endif
    end
  end

  // Only the wrap out of the last row may swap while running, keeping frames whole.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    swap_req   = 1'b0;
    swap_frees = 1'b0;
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
    bright_d   = bright_q;
`endif
    case (state_q)
      S_IDLE: begin
        swap_req = 1'b1;
        if (pend_full) begin
          state_d = S_BLANK;
          row_d   = '0;
          cnt_d   = '0;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d  = S_ON;
          cnt_d    = '0;
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
          bright_d = bright;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ON: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          if (row_q == ROW_LAST) begin
            row_d      = '0;
            swap_req   = 1'b1;
            swap_frees = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    row_n       = '1;
    col_on      = '0;
    frame_start = 1'b0;
    row_bits    = active[row_q * COLS +: COLS];
    if (state_q == S_ON) begin
      row_n[row_q] = 1'b0;
      col_on       = (OCC_LOW != 0) ? ~row_bits : row_bits;
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
      if (int'(cnt_q) >= ((int'(bright_q) + 1) * DWELL) / 8) col_on = '0;
`endif
      frame_start  = (row_q == '0) && (cnt_q == '0);
    end
  end

endmodule

// File: tb/tb_snake_matrix_scan.sv
// tb/tb_snake_matrix_scan.sv - randomized bench checking the scanner against a frame-phase display model
`timescale 1ns/1ps
module tb_snake_matrix_scan;
  import snake_pkg::*;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int N     = ROWS * COLS;
  localparam int BLANK = 2;
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
  localparam int DWELL = 8;
`else
  localparam int DWELL = 4;
`endif
  localparam int P = BLANK + DWELL;
  localparam int F = ROWS * P;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_on;
  logic            frame_start;
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
  logic [2:0]      bright = 3'd7;
`endif

  snake_matrix_scan_if #(.W(N)) upd ();

  snake_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK), .OCC_LOW(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd         (upd),
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
    .bright      (bright),
`endif
    .row_n       (row_n),
    .col_on      (col_on),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fs_seen = 0;

  // Display model: once running, position in the frame is a single phase counter 0..F-1.
  bit              m_run;
  int              m_phase;
  logic [N-1:0]    m_active, m_pend;
  bit              m_pend_full;
  int              m_bright;
  logic [ROWS-1:0] e_row_n;
  logic [COLS-1:0] e_col;
  bit              e_fs, e_ready;

  function automatic void model_reset();
    m_run = 0; m_phase = 0; m_active = '0; m_pend = '0; m_pend_full = 0; m_bright = 7;
  endfunction

  function automatic void model_expect();
    int r, w;
    e_row_n = '1; e_col = '0; e_fs = 0;
    e_ready = !m_pend_full || (m_run && m_phase == F - 1);
    if (m_run) begin
      r = m_phase / P;
      w = m_phase % P;
      if (w >= BLANK) begin
        e_row_n[r] = 1'b0;
        for (int c = 0; c < COLS; c++) e_col[c] = ~m_active[idx(r, c)];
        if ((w - BLANK) >= ((m_bright + 1) * DWELL) / 8) e_col = '0;
        e_fs = (r == 0) && (w == BLANK);
      end
    end
  endfunction

  function automatic void model_advance(input bit v, input logic [N-1:0] f, output bit acc);
    acc = v && e_ready;
    if (!m_run) begin
      if (m_pend_full) begin
        m_run = 1; m_phase = 0; m_active = m_pend; m_pend_full = 0;
      end
    end else begin
      if (m_phase == F - 1 && m_pend_full) begin
        m_active = m_pend; m_pend_full = 0;
      end
      m_phase = (m_phase + 1) % F;
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
      if (m_phase % P == BLANK) m_bright = int'(bright);
`endif
    end
    if (acc) begin
      m_pend = f; m_pend_full = 1;
    end
  endfunction

  function automatic logic [N-1:0] one_dark(input int r, input int c);
    logic [N-1:0] f;
    f = '1;
    f[idx(r, c)] = 1'b0;
    return f;
  endfunction

  task automatic step(input bit v, input logic [N-1:0] f, output bit acc);
    @(negedge clk);
    upd.upd_valid = v;
    upd.upd_field = f;
    #1;
    model_expect();
    checks++; if (row_n !== e_row_n) begin errors++; $display("FAIL row_n @%0t got %h exp %h", $time, row_n, e_row_n); end
    checks++; if (col_on !== e_col) begin errors++; $display("FAIL col_on @%0t got %h exp %h", $time, col_on, e_col); end
    checks++; if (frame_start !== e_fs) begin errors++; $display("FAIL frame_start @%0t got %b exp %b", $time, frame_start, e_fs); end
    checks++; if (upd.upd_ready !== e_ready) begin errors++; $display("FAIL upd_ready @%0t got %b exp %b", $time, upd.upd_ready, e_ready); end
    checks++;
    if (!$onehot0(~row_n) || (row_n === '1 && col_on !== '0)) begin
      errors++; $display("FAIL drivers @%0t got row_n %h col_on %h exp onehot0 low and dark when blank", $time, row_n, col_on);
    end
    if (frame_start === 1'b1) fs_seen++;
    model_advance(v, f, acc);
  endtask

  task automatic wait_fs(input string tag);
    bit a; int k;
    k = 0;
    do begin step(1'b0, '0, a); k++; end while (frame_start !== 1'b1 && k < 2 * F);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL %s frame_start timeout got %b exp 1", tag, frame_start); end
  endtask

  task automatic wait_row(input int r, input string tag);
    bit a; int k; logic [ROWS-1:0] want;
    want = ~(ROWS'(1) << r);
    k = 0;
    do begin step(1'b0, '0, a); k++; end while (row_n !== want && k < 2 * F);
    checks++; if (row_n !== want) begin errors++; $display("FAIL %s row timeout got %h exp %h", tag, row_n, want); end
  endtask

  task automatic offer(input logic [N-1:0] f, input string tag);
    bit a; int k;
    a = 0; k = 0;
    while (!a && k < 2 * F) begin step(1'b1, f, a); k++; end
    checks++; if (!a) begin errors++; $display("FAIL %s accept timeout got stalled exp accepted", tag); end
  endtask

  task automatic test_reset();
    bit a; int fs0;
    upd.upd_valid = 1'b0;
    upd.upd_field = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (row_n !== 8'hFF || col_on !== 8'h00 || frame_start !== 1'b0 || upd.upd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_outputs got %h %h %b %b exp ff 00 0 1", row_n, col_on, frame_start, upd.upd_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fs0 = fs_seen;
    repeat (100) step(1'b0, '0, a);
    checks++; if (fs_seen != fs0) begin errors++; $display("FAIL idle_frame_start got %0d pulses exp 0", fs_seen - fs0); end
    checks++; if (upd.upd_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", upd.upd_ready); end
  endtask

  task automatic test_first_frame();
    bit a; int n; int starts[$];
    step(1'b1, one_dark(0, 0), a);
    step(1'b0, '0, a);
    checks++; if (upd.upd_ready !== 1'b0) begin errors++; $display("FAIL ready_drop got %b exp 0", upd.upd_ready); end
    repeat (BLANK) step(1'b0, '0, a);
    step(1'b0, '0, a);
    checks++; if (row_n !== 8'hFE || col_on !== 8'h01 || frame_start !== 1'b1) begin
      errors++; $display("FAIL first_lit got %h %h %b exp fe 01 1", row_n, col_on, frame_start);
    end
    n = 0;
    repeat (3 * F) begin
      step(1'b0, '0, a); n++;
      if (frame_start === 1'b1) starts.push_back(n);
    end
    checks++;
    if (starts.size() != 3) begin
      errors++; $display("FAIL frame_count got %0d exp 3", starts.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (starts[i] != (i + 1) * F) begin errors++; $display("FAIL frame_period got %0d exp %0d", starts[i], (i + 1) * F); end
      end
    end
  endtask

  task automatic test_mid_frame();
    bit a;
    wait_fs("mid_sync");
    repeat ($urandom_range(1, 20)) step(1'b0, '0, a);
    offer(one_dark(3, 5), "mid_offer");
    wait_fs("mid_swap");
    checks++; if (upd.upd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", upd.upd_ready); end
    wait_row(3, "mid_row3");
    checks++; if (col_on !== 8'h20) begin errors++; $display("FAIL mid_row3_col got %h exp 20", col_on); end
  endtask

  task automatic test_back_to_back();
    bit a; int k;
    wait_fs("b2b_sync");
    offer(one_dark(1, 2), "b2b_first");
    step(1'b1, one_dark(6, 7), a);
    checks++; if (upd.upd_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", upd.upd_ready); end
    k = 0;
    while (!a && k < 2 * F) begin step(1'b1, one_dark(6, 7), a); k++; end
    checks++; if (row_n !== 8'h7F || upd.upd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_swap_accept got %h %b exp 7f 1", row_n, upd.upd_ready);
    end
    wait_fs("b2b_frame_a");
    wait_row(1, "b2b_row1");
    checks++; if (col_on !== 8'h04) begin errors++; $display("FAIL b2b_a_col got %h exp 04", col_on); end
    wait_fs("b2b_frame_b");
    wait_row(6, "b2b_row6");
    checks++; if (col_on !== 8'h80) begin errors++; $display("FAIL b2b_b_col got %h exp 80", col_on); end
  endtask

  task automatic test_random();
    bit a, v; logic [N-1:0] f;
    repeat (600) begin
      v = ($urandom_range(0, 3) == 0);
      f = {$urandom(), $urandom()};
      step(v, f, a);
    end
  endtask

  task automatic test_reset_mid();
    bit a;
    wait_fs("rst_sync");
    offer({$urandom(), $urandom()}, "rst_offer");
    wait_row(4, "rst_row4");
    upd.upd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (row_n !== 8'hFF || col_on !== 8'h00 || upd.upd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got %h %h %b exp ff 00 1", row_n, col_on, upd.upd_ready);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * P) step(1'b0, '0, a);
    checks++; if (row_n !== 8'hFF || upd.upd_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle got %h %b exp ff 1", row_n, upd.upd_ready);
    end
  endtask

`ifdef SNAKE_SCAN_BRIGHTNESS_EN
  task automatic test_brightness();
    bit a; int n;
    wait_fs("br_sync");
    offer('0, "br_offer");
    bright = 3'd3;
    wait_fs("br_lit");
    n = 0;
    repeat (F) begin step(1'b0, '0, a); if (row_n === 8'hFB && col_on !== '0) n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL bright3_on got %0d exp 4", n); end
    bright = 3'd7;
    n = 0;
    repeat (F) begin step(1'b0, '0, a); if (row_n === 8'hFB && col_on !== '0) n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL bright7_on got %0d exp 8", n); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_frame();
    test_mid_frame();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef SNAKE_SCAN_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
